// File: rtl/ftdi_tx_pkg.sv
// Shared types and constants for the FTDI transmit scheduler.
// Header bytes carry a fixed sync nibble so the host can find frame boundaries.
package ftdi_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } state_t;

    localparam logic [3:0] HEADER_SYNC = 4'hA;
    localparam logic [7:0] PAD_BYTE    = 8'h00;

    function automatic logic [7:0] header_byte(input logic [3:0] src);
        return {HEADER_SYNC, src};
    endfunction

endpackage

// File: rtl/ftdi_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly after
// last_grant, wrapping; last_grant itself is the lowest priority.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         any_req
);

    int           idx_int;
    logic [W-1:0] idx;

    always_comb begin
        grant   = '0;
        any_req = |req;
        idx_int = 0;
        idx     = '0;
        // Walk from the farthest offset down so the nearest requester wins last.
        for (int off = N; off >= 1; off--) begin
            idx_int = int'(last_grant) + off;
            if (idx_int >= N) begin
                idx_int = idx_int - N;
            end
            idx = W'(idx_int);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_scheduler.sv
// Round-robin frame scheduler sharing one byte stream between several sources;
// each frame is a header byte plus FRAME_LEN payload bytes, padded on starvation.
module ftdi_tx_scheduler
    import ftdi_tx_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int FRAME_LEN   = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [8*NUM_SOURCES-1:0] s_axis_tdata,
    input  logic [NUM_SOURCES-1:0]   s_axis_tvalid,
    output logic [NUM_SOURCES-1:0]   s_axis_tready,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic [NUM_SOURCES-1:0]   src_enable,
    input  logic                     pad_clear,
    output logic                     busy,
    output logic [3:0]               active_src,
    output logic                     pad_flag,
    output logic [15:0]              frame_count
);

    localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0]    LAST_BYTE  = 8'(FRAME_LEN - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [SW-1:0]   grant_reg, grant_next;
    logic [SW-1:0]   last_grant_reg, last_grant_next;
    logic [7:0]      byte_cnt_reg, byte_cnt_next;
    logic [IW-1:0]   idle_cnt_reg, idle_cnt_next;
    logic [15:0]     frame_count_reg, frame_count_next;
    logic            pad_flag_reg, pad_flag_next;

    logic [NUM_SOURCES-1:0] req;
    logic [SW-1:0]          arb_grant;
    logic                   arb_any;
    logic [7:0]             src_data [NUM_SOURCES];
    logic                   grant_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            assign src_data[gi]      = s_axis_tdata[8*gi +: 8];
            assign s_axis_tready[gi] = (state_reg == PAYLOAD) && (grant_reg == SW'(gi)) && m_axis_tready;
        end
    endgenerate

    assign req         = s_axis_tvalid & src_enable;
    assign grant_valid = s_axis_tvalid[grant_reg];

    rr_arbiter #(
        .N(NUM_SOURCES),
        .W(SW)
    ) u_arb (
        .req       (req),
        .last_grant(last_grant_reg),
        .grant     (arb_grant),
        .any_req   (arb_any)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            last_grant_reg  <= SW'(NUM_SOURCES - 1);
            byte_cnt_reg    <= '0;
            idle_cnt_reg    <= '0;
            frame_count_reg <= '0;
            pad_flag_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            byte_cnt_reg    <= byte_cnt_next;
            idle_cnt_reg    <= idle_cnt_next;
            frame_count_reg <= frame_count_next;
            pad_flag_reg    <= pad_flag_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_grant_next  = last_grant_reg;
        byte_cnt_next    = byte_cnt_reg;
        idle_cnt_next    = idle_cnt_reg;
        frame_count_next = frame_count_reg;
        m_axis_tvalid    = 1'b0;
        m_axis_tdata     = 8'h00;

        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    grant_next      = arb_grant;
                    last_grant_next = arb_grant;
                    state_next      = HEADER;
                end
            end
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = header_byte(4'(grant_reg));
                if (m_axis_tready) begin
                    byte_cnt_next = '0;
                    idle_cnt_next = '0;
                    state_next    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_axis_tvalid = grant_valid;
                m_axis_tdata  = src_data[grant_reg];
                if (grant_valid && m_axis_tready) begin
                    byte_cnt_next = byte_cnt_reg + 8'd1;
                    idle_cnt_next = '0;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        frame_count_next = frame_count_reg + 16'd1;
                        state_next       = IDLE;
                    end
                end else if (!grant_valid) begin
                    // Timeout only fires while valid is low, so no beat is retracted.
                    if (idle_cnt_reg == IDLE_LIMIT) begin
                        state_next = PAD;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + IW'(1);
                    end
                end
            end
            PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = PAD_BYTE;
                if (m_axis_tready) begin
                    byte_cnt_next = byte_cnt_reg + 8'd1;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        frame_count_next = frame_count_reg + 16'd1;
                        state_next       = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A pad event in the same cycle as pad_clear leaves the flag set.
    assign pad_flag_next = (state_reg == PAD) | (pad_flag_reg & ~pad_clear);

    assign busy        = (state_reg != IDLE);
    assign active_src  = busy ? 4'(grant_reg) : 4'd0;
    assign pad_flag    = pad_flag_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_ftdi_tx_scheduler.sv
// Bench for ftdi_tx_scheduler: queued byte sources, an output scoreboard and a
// table of arbitration vectors, plus sequences for padding, backpressure and reset.
module tb_ftdi_tx_scheduler;

    localparam int NS = 4;
    localparam int FL = 4;
    localparam int TO = 8;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic [8*NS-1:0] s_axis_tdata = '0;
    logic [NS-1:0]   s_axis_tvalid = '0;
    logic [NS-1:0]   s_axis_tready;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic [NS-1:0]   src_enable = '0;
    logic            pad_clear = 1'b0;
    logic            busy;
    logic [3:0]      active_src;
    logic            pad_flag;
    logic [15:0]     frame_count;

    ftdi_tx_scheduler #(
        .NUM_SOURCES(NS),
        .FRAME_LEN  (FL),
        .TIMEOUT    (TO)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .src_enable   (src_enable),
        .pad_clear    (pad_clear),
        .busy         (busy),
        .active_src   (active_src),
        .pad_flag     (pad_flag),
        .frame_count  (frame_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] en;
        logic [3:0] grant;
    } vec_t;

    vec_t        tbl [11];
    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  src_q [NS][$];
    logic [7:0]  mq [NS][$];
    logic [7:0]  exp_q [$];
    int          seq [NS];
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = '0;
    int          idle_seen = 0;
    logic [15:0] fc_exp = '0;
    logic [3:0]  got_src;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic update_drv();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                s_axis_tvalid[i]      = 1'b1;
                s_axis_tdata[8*i +: 8] = src_q[i][0];
            end else begin
                s_axis_tvalid[i]      = 1'b0;
                s_axis_tdata[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic sample();
        logic [7:0] e;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL extra_byte: got %02h expected none", m_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                $display("out byte %02h (expect %02h) src %0d", m_axis_tdata, e, active_src);
                check("m_tdata", 32'(m_axis_tdata), 32'(e));
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (s_axis_tready[i] && s_axis_tvalid[i]) begin
                void'(src_q[i].pop_front());
            end
        end
        if (prev_valid && !prev_ready && sys_rst_n) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_data", 32'(m_axis_tdata), 32'(prev_data));
        end
        if (!m_axis_tready) begin
            check("s_tready_low", 32'(s_axis_tready), 32'd0);
        end
        if (busy && !m_axis_tvalid) begin
            idle_seen++;
        end
        prev_valid = m_axis_tvalid;
        prev_ready = m_axis_tready;
        prev_data  = m_axis_tdata;
    endtask

    task automatic cycle();
        @(negedge sys_clk);
        update_drv();
        #1;
        sample();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_src(input int i, input logic [7:0] b);
        src_q[i].push_back(b);
        mq[i].push_back(b);
    endtask

    task automatic expect_frame(input logic [3:0] g);
        exp_q.push_back({4'hA, g});
        for (int k = 0; k < FL; k++) begin
            exp_q.push_back(mq[g].pop_front());
        end
    endtask

    task automatic run_frame(input logic [15:0] target, output logic [3:0] got);
        int  n;
        logic first;
        n     = 0;
        first = 1'b1;
        got   = 4'hF;
        if (busy) begin
            got   = active_src;
            first = 1'b0;
        end
        while (frame_count != target && n < 300) begin
            cycle();
            n++;
            if (first && busy) begin
                got   = active_src;
                first = 1'b0;
            end
        end
        if (n >= 300) begin
            nvec++;
            nerr++;
            $display("FAIL frame_timeout: frame_count %0d expected %0d", frame_count, target);
        end
    endtask

    task automatic flush(input logic check_empty);
        if (check_empty) begin
            check("exp_empty", 32'(exp_q.size()), 32'd0);
        end
        src_enable = '0;
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            mq[i].delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
        check({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
        check({tag, "_active_src"}, 32'(active_src), 32'd0);
        check({tag, "_pad_flag"}, 32'(pad_flag), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = '{4'b1011, 4'd0};
        tbl[1]  = '{4'b1011, 4'd1};
        tbl[2]  = '{4'b1011, 4'd3};
        tbl[3]  = '{4'b1011, 4'd0};
        tbl[4]  = '{4'b1001, 4'd3};
        tbl[5]  = '{4'b1001, 4'd0};
        tbl[6]  = '{4'b0100, 4'd2};
        tbl[7]  = '{4'b0100, 4'd2};
        tbl[8]  = '{4'b1111, 4'd3};
        tbl[9]  = '{4'b1111, 4'd0};
        tbl[10] = '{4'b1111, 4'd1};
        for (int i = 0; i < NS; i++) seq[i] = 0;

        // Reset state
        repeat (3) cycle();
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        cycle();

        // Arbitration vectors; every enabled source always has a full frame queued
        for (int v = 0; v < 11; v++) begin
            src_enable = tbl[v].en;
            for (int i = 0; i < NS; i++) begin
                if (tbl[v].en[i]) begin
                    for (int k = 0; k < FL; k++) begin
                        push_src(i, 8'(i * 64 + seq[i]));
                        seq[i] = (seq[i] + 1) % 64;
                    end
                end
            end
            expect_frame(tbl[v].grant);
            fc_exp = fc_exp + 16'd1;
            run_frame(fc_exp, got_src);
            check("vec_grant", 32'(got_src), 32'(tbl[v].grant));
            check("vec_frame_count", 32'(frame_count), 32'(fc_exp));
        end
        check("pad_flag_clean", 32'(pad_flag), 32'd0);
        flush(1'b1);

        // Single source 2 with explicit bytes
        src_enable = 4'b0100;
        push_src(2, 8'h11);
        push_src(2, 8'h22);
        push_src(2, 8'h33);
        push_src(2, 8'h44);
        expect_frame(4'd2);
        fc_exp = fc_exp + 16'd1;
        run_frame(fc_exp, got_src);
        check("single_grant", 32'(got_src), 32'd2);
        check("single_frame_count", 32'(frame_count), 32'(fc_exp));
        check("single_pad_flag", 32'(pad_flag), 32'd0);
        flush(1'b1);

        // Starved frame pads after TIMEOUT idle cycles; clear held throughout, set wins
        src_enable = 4'b0010;
        push_src(1, 8'h5A);
        push_src(1, 8'h5B);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5B);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        idle_seen = 0;
        pad_clear = 1'b1;
        fc_exp = fc_exp + 16'd1;
        run_frame(fc_exp, got_src);
        check("pad_grant", 32'(got_src), 32'd1);
        check("pad_idle_cycles", 32'(idle_seen), 32'(TO));
        check("pad_frame_count", 32'(frame_count), 32'(fc_exp));
        check("pad_flag_set_wins", 32'(pad_flag), 32'd1);
        cycle();
        check("pad_flag_cleared", 32'(pad_flag), 32'd0);
        pad_clear = 1'b0;
        cycle();
        check("pad_flag_stays_clear", 32'(pad_flag), 32'd0);
        flush(1'b1);

        // Backpressure in HEADER and mid-PAYLOAD, enable dropped mid-frame
        src_enable = 4'b0001;
        push_src(0, 8'hC1);
        push_src(0, 8'hC2);
        push_src(0, 8'hC3);
        push_src(0, 8'hC4);
        expect_frame(4'd0);
        m_axis_tready = 1'b0;
        n = 0;
        while (!busy && n < 20) begin
            cycle();
            n++;
        end
        check("bp_busy", 32'(busy), 32'd1);
        repeat (5) cycle();
        m_axis_tready = 1'b1;
        cycle();
        cycle();
        src_enable    = 4'b0000;
        m_axis_tready = 1'b0;
        repeat (5) cycle();
        m_axis_tready = 1'b1;
        fc_exp = fc_exp + 16'd1;
        run_frame(fc_exp, got_src);
        check("bp_grant", 32'(got_src), 32'd0);
        check("bp_frame_count", 32'(frame_count), 32'(fc_exp));
        check("bp_src_drained", 32'(src_q[0].size()), 32'd0);
        flush(1'b1);

        // Reset mid-PAYLOAD, then lowest requester wins
        src_enable = 4'b0100;
        push_src(2, 8'hD1);
        push_src(2, 8'hD2);
        push_src(2, 8'hD3);
        push_src(2, 8'hD4);
        expect_frame(4'd2);
        n = 0;
        while (src_q[2].size() != 3 && n < 50) begin
            cycle();
            n++;
        end
        check("mid_payload_reached", 32'(src_q[2].size()), 32'd3);
        sys_rst_n = 1'b0;
        cycle();
        sys_rst_n = 1'b1;
        check_reset_outputs("midrst");
        flush(1'b0);
        fc_exp = '0;
        src_enable = 4'b1010;
        for (int k = 0; k < FL; k++) begin
            push_src(1, 8'(8'h60 + k));
            push_src(3, 8'(8'h70 + k));
        end
        expect_frame(4'd1);
        expect_frame(4'd3);
        fc_exp = fc_exp + 16'd1;
        run_frame(fc_exp, got_src);
        check("post_rst_grant", 32'(got_src), 32'd1);
        fc_exp = fc_exp + 16'd1;
        run_frame(fc_exp, got_src);
        check("post_rst_grant2", 32'(got_src), 32'd3);
        check("post_rst_frame_count", 32'(frame_count), 32'(fc_exp));
        cycle();
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ftdi_tx_scheduler.md
Name: ftdi_tx_scheduler

Overview:
- Shares the single byte-wide FTDI transmit stream between NUM_SOURCES AXI-Stream byte producers, e.g. ADC capture, debug log and status.
- Grants the stream round-robin, one fixed-length frame at a time.
- Prefixes each frame with a header byte so the host can demultiplex; pads starved frames after a timeout so framing never breaks.
- Sits in the sys_clk domain, directly upstream of the FTDI transmit FIFO input (tdata/tvalid/tready).

Parameters:
- NUM_SOURCES, 4, number of requesters; legal range 2..16.
- FRAME_LEN, 32, payload bytes per frame, excluding header; legal range 1..255.
- TIMEOUT, 1024, consecutive mid-frame idle cycles before padding starts; must be >= 1.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  synchronous, active-low reset.
- s_axis_tdata  input  8*NUM_SOURCES  source i data on bits [8i+7:8i].
- s_axis_tvalid  input  NUM_SOURCES  per-source valid.
- s_axis_tready  output  NUM_SOURCES  per-source ready.
- m_axis_tdata  output  8  byte to the FTDI transmit FIFO.
- m_axis_tvalid  output  1  output valid.
- m_axis_tready  input  1  FTDI transmit FIFO ready.
- src_enable  input  NUM_SOURCES  per-source arbitration enable.
- pad_clear  input  1  clears pad_flag.
- busy  output  1  high in any state other than IDLE.
- active_src  output  4  index of the granted source; 0 when idle.
- pad_flag  output  1  sticky: a frame was padded.
- frame_count  output  16  completed frames, wrapping.

Behaviour:
- Reset (sys_rst_n low at a clock edge):
  - state=IDLE; all s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0.
  - busy=0, active_src=0, pad_flag=0, frame_count=0.
  - Round-robin pointer set so source 0 has highest priority.
  - Reset mid-frame abandons the frame with no trailing bytes; the host resyncs on the next header.
- Requests: req = s_axis_tvalid & src_enable.
- State machine:
  - IDLE: if req != 0, grant the first requesting index strictly after last_grant, wrapping modulo NUM_SOURCES. Latch grant; last_grant <= grant; go to HEADER. Grant decision is one cycle; the header appears the next cycle.
  - HEADER:
    - m_axis_tvalid=1; m_axis_tdata={4'hA, grant[3:0]}; all s_axis_tready=0.
    - On m_axis_tready: byte_cnt<=0, idle_cnt<=0, go to PAYLOAD.
  - PAYLOAD (combinational pass-through, zero latency):
    - m_axis_tdata = s_axis_tdata[grant]; m_axis_tvalid = s_axis_tvalid[grant].
    - s_axis_tready[grant] = m_axis_tready; all other readies 0.
    - Each accepted beat: byte_cnt++, idle_cnt<=0.
    - Each cycle with s_axis_tvalid[grant]=0: idle_cnt++.
    - Beat accepted with byte_cnt==FRAME_LEN-1: frame_count++, go to IDLE.
    - idle_cnt reaches TIMEOUT-1 while still idle: go to PAD. This can only occur while m_axis_tvalid=0, so no valid retraction.
  - PAD:
    - m_axis_tvalid=1; m_axis_tdata=8'h00; all s_axis_tready=0.
    - pad_flag<=1.
    - Each accepted byte: byte_cnt++.
    - Last byte (byte_cnt==FRAME_LEN-1) accepted: frame_count++, go to IDLE.
- Frame integrity: a frame always emits exactly 1+FRAME_LEN bytes unless reset intervenes.
- Held valid: m_axis_tvalid/m_axis_tdata stay stable while m_axis_tready=0 in HEADER and PAD.
- src_enable changes: deasserting a source mid-frame does not abort its frame; enable affects only the next IDLE arbitration.
- Back-to-back frames: IDLE costs one bubble cycle between frames.
- With one requester, it is granted repeatedly.
- pad_clear and a pad event in the same cycle: the set wins.
- frame_count wraps 16'hFFFF -> 0.

Decomposition:
- Package ftdi_tx_pkg: state enum (IDLE, HEADER, PAYLOAD, PAD), HEADER_SYNC=4'hA, PAD_BYTE=8'h00.
- Sub-module rr_arbiter: parameter N; inputs req[N], last_grant; outputs grant index and any_req. Purely combinational, so it can be reused by other shared-resource schedulers.

Test Plan:
1. Single source 2 (FRAME_LEN=4) streams 0x11,0x22,0x33,0x44, tready=1. Expect m_axis output A2,11,22,33,44; frame_count=1; pad_flag=0.
2. Sources 0,1,3 continuously valid, 3 frames. Expect grant order 0,1,3 and headers A0,A1,A3. Then a 4th frame returns to source 0.
3. Fairness after wrap: last grant 3 with sources 0 and 3 requesting. Expect source 0 next.
4. Source 1 sends 2 of 4 bytes then drops valid, TIMEOUT=8. Expect 8 idle cycles, then bytes 00,00; pad_flag=1; frame_count increments. Then pad_clear=1 gives pad_flag=0.
5. m_axis_tready held low 5 cycles during HEADER and mid-PAYLOAD. Expect data/valid stable, no source beat lost or duplicated, s_axis_tready low throughout.
6. sys_rst_n low for one cycle mid-PAYLOAD. Expect the next cycle to show m_axis_tvalid=0, all readies 0, busy=0, frame_count=0. The next grant goes to the lowest requesting index.
